mudi_issue_ctrl: RTL and testbench
==================================

# mudi_issue_ctrl

Issue-side controller for the multiply/divide unit: it drives the unit's start/opcode inputs and stalls the decode stage while a multiply or divide result is pending. It sits between the D/E pipeline registers and the multiply/divide unit. A local shadow busy counter produces the stall from registered state only, so the busy output of the multiply/divide unit is not on the stall path. That busy output is used only for a sticky consistency check.

## Interface
Parameters
- MUL_CYCLES, 5: busy cycles the unit reports after a mult/multu start.
- DIV_CYCLES, 10: busy cycles the unit reports after a div/divu start.

Ports
- clk, in, 1: single clock. All state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- D_isMd, in, 1: the instruction in D uses the multiply/divide unit (mult, multu, div, divu, mthi, mtlo, mfhi, mflo).
- D_mdOp, in, 3: opcode of that instruction.
  - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo.
  - 6 mfhi, 7 mflo.
- MUDI_isBusy, in, 1: busy output of the multiply/divide unit, used for checking only.
- D_stall, out, 1: hold D and F, and insert a bubble into E.
- E_isStart, out, 1: start pulse to the unit.
- E_mudiOp, out, 3: opcode presented to the unit.
- E_readHi, out, 1: the E instruction is mfhi.
- E_readLo, out, 1: the E instruction is mflo.
- busyErr, out, 1: sticky flag for a mismatch between the shadow counter and the unit.

## Operation
- State:
  - E_valid (1 bit).
  - E_op (3 bits).
  - cnt (4 bits; must hold DIV_CYCLES).
  - busyErr (1 bit).
- Derived signal: E_isMulDiv = E_valid & (E_op ≤ 3).
- Stall: D_stall = D_isMd & (E_isMulDiv | cnt > 1). This is a function of registered state and D inputs only.
- E register update, each edge:
  - If D_stall: E_valid←0 (bubble).
  - Otherwise: E_valid←D_isMd, E_op←D_mdOp.
- Outputs:
  - E_isStart = E_valid & (E_op ≤ 5).
  - E_mudiOp = E_op.
  - E_readHi = E_valid & (E_op==6).
  - E_readLo = E_valid & (E_op==7).
- Shadow counter, per edge, in priority order:
  1. reset → 0.
  2. E_isMulDiv → MUL_CYCLES for op 0/1, DIV_CYCLES for op 2/3.
  3. cnt>0 → cnt-1.
  4. Otherwise hold.
- mthi/mtlo start the unit but do not load cnt. While cnt>0 they stall in D like every other MD instruction.
- Consistency check: on any non-reset edge where MUDI_isBusy ≠ (cnt≠0), busyErr←1. busyErr stays set until reset.
- Non-MD instructions are never stalled by this block and pass through as bubbles (E_valid=0).

## Timing
- Reset values: D_stall=0, E_isStart=0, E_mudiOp=0, E_readHi=0, E_readLo=0, busyErr=0, cnt=0.
- Reset mid-operation clears cnt and E_valid immediately. Reset is assumed to reset the unit on the same edge, so no error is flagged.
- An MD instruction spends exactly one cycle in E. E_isStart is therefore a single-cycle pulse per issued instruction.
- Mult/div issue:
  - The start edge loads cnt. The unit is busy for MUL_CYCLES or DIV_CYCLES cycles after that edge.
  - A following MD instruction held in D is released on the cycle where cnt==1. It enters E exactly when cnt and the unit's busy both reach 0.
- Back-to-back case: an MD instruction in D while a mult/div is in E stalls, via E_isMulDiv.
- Minimum gap between starts:
  - mult followed by any MD instruction: MUL_CYCLES+1 cycles.
  - div followed by any MD instruction: DIV_CYCLES+1 cycles.
  - mthi/mtlo/mfhi/mflo followed by any MD instruction: 1 cycle (no stall).
- mfhi/mflo in E see final HI/LO, because issue only occurs once busy is clear.

## Structure
- Shared package `mudi_pkg` holds:
  - the opcode constants (OP_MULT … OP_MFLO);
  - MUL_CYCLES and DIV_CYCLES defaults.
- The multiply/divide unit also uses `mudi_pkg`.
- One natural sub-module, `mudi_shadow_cnt`, owns the counter load/decrement logic and the busyErr check. The top level holds the E register and the stall/output logic.

## Test plan
- Reset, then mult in D for one cycle with no follow-on MD instructions → E_isStart pulses once with E_mudiOp=0. cnt reads 5,4,3,2,1,0 on the following cycles. busyErr stays 0 against a correct unit model.
- div followed immediately by mflo → D_stall=1 for 10 cycles. mflo enters E 11 cycles after div, with E_readLo=1 and E_isStart=0.
- mthi, mtlo, mfhi on consecutive cycles → no stall, with one E_isStart pulse each for op 4 and op 5.
- multu, then a non-MD instruction, then mfhi → the non-MD instruction advances and mfhi stalls until cnt==1. E_readHi is asserted 6 cycles after the multu start.
- Unit model forced to deassert busy one cycle early after a mult → busyErr rises on that edge and stays 1 until reset.
- Reset asserted 3 cycles into a div with mflo stalled in D → the next cycle has D_stall=0, cnt=0, E_isStart=0 and busyErr=0.

Source files
------------

// File: rtl/mudi_pkg.sv
// Shared definitions for the multiply/divide unit and its issue controller:
// opcode encoding and default busy latencies.
package mudi_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } md_op_e;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mudi_shadow_cnt.sv
// Shadow copy of the multiply/divide unit's busy time, plus a sticky flag
// raised whenever the real unit disagrees with the shadow count.
module mudi_shadow_cnt
  import mudi_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  input  logic             unit_busy,
  output logic [CNT_W-1:0] cnt,
  output logic             busy_err
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      busy_err <= 1'b0;
    end else begin
      if (load)
        cnt <= load_div ? DIV_LOAD : MUL_LOAD;
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);

      // Compared against the pre-edge count, which is what the unit reports.
      if (unit_busy != (cnt != '0))
        busy_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mudi_issue_ctrl.sv
// Issue-side controller for the multiply/divide unit: one-deep E register,
// start/opcode drive, and a decode stall computed from registered state only.
module mudi_issue_ctrl
  import mudi_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       D_isMd,
  input  logic [2:0] D_mdOp,
  input  logic       MUDI_isBusy,
  output logic       D_stall,
  output logic       E_isStart,
  output logic [2:0] E_mudiOp,
  output logic       E_readHi,
  output logic       E_readLo,
  output logic       busyErr
);

  logic             E_valid;
  logic [2:0]       E_op;
  logic             E_isMulDiv;
  logic [CNT_W-1:0] cnt;

  mudi_shadow_cnt #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .load      (E_isMulDiv),
    .load_div  (E_op[1]),
    .unit_busy (MUDI_isBusy),
    .cnt       (cnt),
    .busy_err  (busyErr)
  );

  // Releasing at cnt==1 lets the next instruction reach E exactly as the
  // unit goes idle; E_isMulDiv covers the cycle before cnt is loaded.
  always_comb begin
    E_isMulDiv = E_valid & (E_op <= OP_DIVU);
    D_stall    = D_isMd & (E_isMulDiv | (cnt > CNT_W'(1)));
    E_isStart  = E_valid & (E_op <= OP_MTLO);
    E_mudiOp   = E_op;
    E_readHi   = E_valid & (E_op == OP_MFHI);
    E_readLo   = E_valid & (E_op == OP_MFLO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      E_valid <= 1'b0;
      E_op    <= OP_MULT;
    end else if (D_stall) begin
      E_valid <= 1'b0;
    end else begin
      E_valid <= D_isMd;
      E_op    <= D_mdOp;
    end
  end

endmodule

// File: tb/tb_mudi_issue_ctrl.sv
// Scoreboard bench for mudi_issue_ctrl: directed issue sequences push the
// expected E-stage event; a negedge monitor pops and compares.
module tb_mudi_issue_ctrl;
  import mudi_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       D_isMd;
  logic [2:0] D_mdOp;
  logic       MUDI_isBusy;
  logic       D_stall;
  logic       E_isStart;
  logic [2:0] E_mudiOp;
  logic       E_readHi;
  logic       E_readLo;
  logic       busyErr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int unit_cnt = 0;
  bit unit_early = 1'b0;

  typedef struct {
    logic [2:0] op;
    logic       start;
    logic       rhi;
    logic       rlo;
    int         at;
  } exp_t;
  exp_t sb[$];

  mudi_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_isMd      (D_isMd),
    .D_mdOp      (D_mdOp),
    .MUDI_isBusy (MUDI_isBusy),
    .D_stall     (D_stall),
    .E_isStart   (E_isStart),
    .E_mudiOp    (E_mudiOp),
    .E_readHi    (E_readHi),
    .E_readLo    (E_readLo),
    .busyErr     (busyErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural unit: busy for 5 (mult) or 10 (div) cycles after the start
  // edge; unit_early makes a mult finish one cycle short.
  always @(posedge clk) begin
    if (reset)
      unit_cnt <= 0;
    else if (E_isStart && E_mudiOp <= 3'd3)
      unit_cnt <= (E_mudiOp < 3'd2) ? (unit_early ? 4 : 5) : 10;
    else if (unit_cnt > 0)
      unit_cnt <= unit_cnt - 1;
  end
  assign MUDI_isBusy = (unit_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One decode cycle: present D, check stall/count/flag, then clock.
  task automatic cycle(input logic md, input logic [2:0] op, input logic exp_stall,
                       input int exp_cnt, input logic exp_err);
    D_isMd = md;
    D_mdOp = op;
    #1;
    check("D_stall", D_stall, exp_stall);
    check("cnt", 32'(dut.u_shadow.cnt), exp_cnt);
    check("busyErr", busyErr, exp_err);
    if (md && !exp_stall)
      sb.push_back('{op, op <= 3'd5, op == 3'd6, op == 3'd7, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    D_isMd = 1'b0;
    D_mdOp = 3'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (E_isStart || E_readHi || E_readLo)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: op %0d in E with nothing expected (cycle %0d)",
                 E_mudiOp, cyc);
      end else begin
        e = sb.pop_front();
        check("E_mudiOp", E_mudiOp, e.op);
        check("E_isStart", E_isStart, e.start);
        check("E_readHi", E_readHi, e.rhi);
        check("E_readLo", E_readLo, e.rlo);
        check("issue_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    check("rst_D_stall", D_stall, 0);
    check("rst_E_isStart", E_isStart, 0);
    check("rst_E_mudiOp", E_mudiOp, 0);
    check("rst_E_readHi", E_readHi, 0);
    check("rst_E_readLo", E_readLo, 0);
    check("rst_busyErr", busyErr, 0);
    check("rst_cnt", 32'(dut.u_shadow.cnt), 0);

    // mult alone: count 5..0 after the start edge
    cycle(1, OP_MULT, 0, 0, 0);
    cycle(0, OP_MULT, 0, 0, 0);
    for (int c = 5; c >= 0; c--) cycle(0, 3'd0, 0, c, 0);

    // div then mflo: ten stall cycles, mflo in E 11 cycles after div
    cycle(1, OP_DIV, 0, 0, 0);
    cycle(1, OP_MFLO, 1, 0, 0);
    for (int c = 10; c >= 2; c--) cycle(1, OP_MFLO, 1, c, 0);
    cycle(1, OP_MFLO, 0, 1, 0);
    cycle(0, 3'd0, 0, 0, 0);

    // mthi, mtlo, mfhi back to back: no stall
    cycle(1, OP_MTHI, 0, 0, 0);
    cycle(1, OP_MTLO, 0, 0, 0);
    cycle(1, OP_MFHI, 0, 0, 0);
    cycle(0, 3'd0, 0, 0, 0);
    cycle(0, 3'd0, 0, 0, 0);

    // multu, non-MD (garbage opcode), mfhi held until cnt==1
    cycle(1, OP_MULTU, 0, 0, 0);
    cycle(0, OP_DIV, 0, 0, 0);
    for (int c = 5; c >= 2; c--) cycle(1, OP_MFHI, 1, c, 0);
    cycle(1, OP_MFHI, 0, 1, 0);
    cycle(0, 3'd0, 0, 0, 0);
    cycle(0, 3'd0, 0, 0, 0);

    // unit drops busy one cycle early after a mult
    unit_early = 1'b1;
    cycle(1, OP_MULT, 0, 0, 0);
    cycle(0, 3'd0, 0, 0, 0);
    for (int c = 5; c >= 1; c--) cycle(0, 3'd0, 0, c, 0);
    cycle(0, 3'd0, 0, 0, 1);
    cycle(0, 3'd0, 0, 0, 1);
    cycle(1, OP_MTHI, 0, 0, 1);
    cycle(0, 3'd0, 0, 0, 1);
    unit_early = 1'b0;
    do_reset();
    #1;
    check("err_cleared", busyErr, 0);

    // reset three cycles into a div with mflo stalled in D
    cycle(1, OP_DIV, 0, 0, 0);
    cycle(1, OP_MFLO, 1, 0, 0);
    cycle(1, OP_MFLO, 1, 10, 0);
    cycle(1, OP_MFLO, 1, 9, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_D_stall", D_stall, 0);
    check("midrst_cnt", 32'(dut.u_shadow.cnt), 0);
    check("midrst_E_isStart", E_isStart, 0);
    check("midrst_busyErr", busyErr, 0);
    cycle(1, OP_MFLO, 0, 0, 0);
    cycle(0, 3'd0, 0, 0, 0);
    cycle(0, 3'd0, 0, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
